sys_clk_timer_sequencer: RTL
============================

Name: sys_clk_timer_sequencer

Overview:
- Avalon-MM master that owns the 16-bit sys_clk interval-timer slave (6 registers, address 0..5).
- Programs the 32-bit period and mode, starts the timer, services its irq by clearing status, and counts ticks.
- Takes snapshot requests from a requester and returns the 32-bit live count.
- Sits between the system control logic and the timer slave so that software-free logic sees one simple request interface.

Parameters:
- TICK_W, 32, width of tick_count.
- READ_LATENCY, 1, cycles from address presented to slave readdata valid. Only 1 is supported; other values are a synthesis error.

Ports:
- clk, input, 1, clock.
- reset_n, input, 1, asynchronous active-low reset.
- cfg_req, input, 1, one-cycle pulse: load cfg_period/cfg_continuous and (re)start the timer.
- cfg_period, input, 32, timer period, sampled when cfg_req=1.
- cfg_continuous, input, 1, timer CONT bit, sampled when cfg_req=1.
- snap_req, input, 1, one-cycle pulse: request a counter snapshot.
- tmr_address, output, 3, slave address.
- tmr_chipselect, output, 1, slave chipselect.
- tmr_write_n, output, 1, slave write strobe, active low.
- tmr_writedata, output, 16, slave write data.
- tmr_readdata, input, 16, slave registered read data.
- tmr_irq, input, 1, slave interrupt.
- busy, output, 1, FSM not in IDLE.
- cfg_done, output, 1, one-cycle pulse when the start write completes.
- tick, output, 1, one-cycle pulse per serviced timeout.
- tick_count, output, TICK_W, serviced timeouts since reset; wraps to 0.
- snap_valid, output, 1, one-cycle pulse; snap_value is valid in that cycle.
- snap_value, output, 32, captured counter {high, low}.

Behaviour:
- Reset values: all outputs 0 except tmr_write_n=1. FSM=IDLE, pending flags cleared, latched cfg cleared.
- Pending latches:
  - cfg_req sets cfg_pend and latches period/continuous. A later cfg_req before service overwrites the latch; only the newest config is applied.
  - snap_req sets snap_pend. Multiple requests merge into one.
  - Pending flags clear on the cycle the FSM leaves IDLE for that job.
- IDLE arbitration (fixed priority, evaluated each cycle): tmr_irq → ACK; else cfg_pend → WR_PL; else snap_pend → SNAP_WR.
- Bus cycles: every write is one cycle with chipselect=1, write_n=0. Reads use chipselect=1, write_n=1, and data is sampled the following cycle.
- Write states (one cycle each):
  - WR_PL: addr 2, data period[15:0].
  - WR_PH: addr 3, data period[31:16].
  - WR_CTRL: addr 1, data {12'b0, 1'b0 STOP, 1'b1 START, cont, 1'b1 ITO}; cfg_done pulses in the next cycle; → IDLE.
  - ACK: addr 0, data 0. This clears the slave timeout flag. tick pulses the next cycle and tick_count increments; → IDLE.
- Snapshot states:
  - SNAP_WR: addr 4, write data 0; the slave latches its counter.
  - RD_L: addr 4, read.
  - RD_H: addr 5, read; capture tmr_readdata into snap_value[15:0].
  - RD_CAP: bus idle; capture tmr_readdata into snap_value[31:16]; snap_valid=1; → IDLE.
- Bus idle outside these states: chipselect=0, write_n=1, address 0, writedata 0.
- Each job is atomic: tmr_irq or new requests arriving mid-job wait for IDLE. Worst-case irq service latency is 5 cycles (snapshot in progress) + 1.
- tmr_irq deasserts the cycle after ACK, so IDLE after ACK does not re-service. If the slave raises a timeout in the same cycle as the ACK write, the slave clear wins and that tick is lost. This is acceptable and documented; it only occurs for periods < 7.
- Cfg writes stop the slave counter (period write forces reload). The START in WR_CTRL restarts it.
- Reset mid-job: the FSM aborts immediately to IDLE. The slave is left as-is, and the next cfg_req re-programs it fully.
- snap_value holds its last value between captures.

Test Plan:
- Reset release, cfg_req with period=0x0000_0010 and cont=1: writes are seen as (2,0x0010), (3,0x0000), (1,0x0007) on consecutive cycles; cfg_done pulses in the 4th cycle; busy is high for 3 cycles.
- Slave model times out after period 0x10 in continuous mode: tick pulses every ~17+ cycles; each pulse is preceded by a write to addr 0; tick_count reaches 5 after 5 timeouts with no duplicate counting.
- snap_req with slave counter = 0x0001_2345: sequence is write 4, read 4, read 5; snap_valid with snap_value=0x0001_2345 arrives 4 cycles after leaving IDLE.
- tmr_irq, cfg_req and snap_req asserted in the same cycle: order is ACK, then cfg writes, then snapshot; all three complete; both pending flags end clear.
- Two cfg_req pulses (period 0x100 then 0x200) while a snapshot is in progress: only 0x200 is written, and cfg_done pulses once.
- reset_n asserted during WR_PH: all outputs return to reset values asynchronously; after release the FSM is idle and tick_count=0.

Source files
------------

// File: rtl/sys_clk_timer_sequencer.sv
// sys_clk_timer_sequencer
// Avalon-MM master that owns the 16-bit sys_clk interval-timer slave.
// It programs period/mode and starts the timer, services the timeout irq by
// clearing the status register and counting ticks, and takes counter
// snapshots on request.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   cfg_req             pulse: latch cfg_period/cfg_continuous, (re)start timer
//   cfg_period          32-bit timer period
//   cfg_continuous      timer CONT bit
//   snap_req            pulse: request a counter snapshot
//   tmr_address         slave address (0..5)
//   tmr_chipselect      slave chipselect
//   tmr_write_n         slave write strobe, active low
//   tmr_writedata       slave write data
//   tmr_readdata        slave read data, valid one cycle after the read
//   tmr_irq             slave interrupt
//   busy                FSM not in IDLE
//   cfg_done            pulse after the start write
//   tick                pulse per serviced timeout
//   tick_count          serviced timeouts since reset (wraps)
//   snap_valid          pulse; snap_value valid in that cycle
//   snap_value          captured counter {high, low}
module sys_clk_timer_sequencer #(
  parameter int TICK_W       = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cfg_req,
  input  logic [31:0]       cfg_period,
  input  logic              cfg_continuous,
  input  logic              snap_req,
  output logic [2:0]        tmr_address,
  output logic              tmr_chipselect,
  output logic              tmr_write_n,
  output logic [15:0]       tmr_writedata,
  input  logic [15:0]       tmr_readdata,
  input  logic              tmr_irq,
  output logic              busy,
  output logic              cfg_done,
  output logic              tick,
  output logic [TICK_W-1:0] tick_count,
  output logic              snap_valid,
  output logic [31:0]       snap_value
);

  // The read-capture states assume data arrives exactly one cycle after the
  // address; any other latency would capture the wrong beat.
  if (READ_LATENCY != 1) begin : g_latency_check
    $error("sys_clk_timer_sequencer: only READ_LATENCY = 1 is supported");
  end

  localparam logic [TICK_W-1:0] TICK_ONE = TICK_W'(1);

  typedef enum logic [3:0] {
    IDLE, WR_PL, WR_PH, WR_CTRL, ACK, SNAP_WR, RD_L, RD_H, RD_CAP
  } state_t;

  state_t      state;
  logic        cfg_pend;
  logic        snap_pend;
  logic [31:0] cfg_period_lat;
  logic        cfg_cont_lat;
  // Config frozen for the duration of a programming job, so a cfg_req that
  // lands mid-job cannot mix halves of two different periods.
  logic [31:0] job_period;
  logic        job_cont;

  assign busy = (state != IDLE);

  // Bus outputs are registered: each value is loaded on the edge that enters
  // the state it belongs to, so the bus shows it for that whole state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      cfg_pend       <= 1'b0;
      snap_pend      <= 1'b0;
      cfg_period_lat <= 32'h0;
      cfg_cont_lat   <= 1'b0;
      job_period     <= 32'h0;
      job_cont       <= 1'b0;
      tmr_address    <= 3'd0;
      tmr_chipselect <= 1'b0;
      tmr_write_n    <= 1'b1;
      tmr_writedata  <= 16'h0;
      cfg_done       <= 1'b0;
      tick           <= 1'b0;
      tick_count     <= '0;
      snap_valid     <= 1'b0;
      snap_value     <= 32'h0;
    end else begin
      // Default: bus idle, pulses low.
      tmr_address    <= 3'd0;
      tmr_chipselect <= 1'b0;
      tmr_write_n    <= 1'b1;
      tmr_writedata  <= 16'h0;
      cfg_done       <= 1'b0;
      tick           <= 1'b0;
      snap_valid     <= 1'b0;

      case (state)
        IDLE: begin
          if (tmr_irq) begin
            state          <= ACK;
            tmr_address    <= 3'd0;
            tmr_chipselect <= 1'b1;
            tmr_write_n    <= 1'b0;
            tmr_writedata  <= 16'h0;
          end else if (cfg_pend) begin
            state          <= WR_PL;
            cfg_pend       <= 1'b0;
            job_period     <= cfg_period_lat;
            job_cont       <= cfg_cont_lat;
            tmr_address    <= 3'd2;
            tmr_chipselect <= 1'b1;
            tmr_write_n    <= 1'b0;
            tmr_writedata  <= cfg_period_lat[15:0];
          end else if (snap_pend) begin
            state          <= SNAP_WR;
            snap_pend      <= 1'b0;
            tmr_address    <= 3'd4;
            tmr_chipselect <= 1'b1;
            tmr_write_n    <= 1'b0;
            tmr_writedata  <= 16'h0;
          end
        end
        WR_PL: begin
          state          <= WR_PH;
          tmr_address    <= 3'd3;
          tmr_chipselect <= 1'b1;
          tmr_write_n    <= 1'b0;
          tmr_writedata  <= job_period[31:16];
        end
        WR_PH: begin
          state          <= WR_CTRL;
          tmr_address    <= 3'd1;
          tmr_chipselect <= 1'b1;
          tmr_write_n    <= 1'b0;
          // {STOP=0, START=1, CONT, ITO=1}
          tmr_writedata  <= {12'h000, 1'b0, 1'b1, job_cont, 1'b1};
        end
        WR_CTRL: begin
          state    <= IDLE;
          cfg_done <= 1'b1;
        end
        ACK: begin
          state      <= IDLE;
          tick       <= 1'b1;
          tick_count <= tick_count + TICK_ONE;
        end
        SNAP_WR: begin
          state          <= RD_L;
          tmr_address    <= 3'd4;
          tmr_chipselect <= 1'b1;
        end
        RD_L: begin
          state          <= RD_H;
          tmr_address    <= 3'd5;
          tmr_chipselect <= 1'b1;
        end
        RD_H: begin
          // Data for the low-half read issued in RD_L.
          state            <= RD_CAP;
          snap_value[15:0] <= tmr_readdata;
        end
        RD_CAP: begin
          state             <= IDLE;
          snap_value[31:16] <= tmr_readdata;
          snap_valid        <= 1'b1;
        end
        default: state <= IDLE;
      endcase

      // New requests are placed after the IDLE clears so a request arriving
      // on the very edge its predecessor is taken stays pending.
      if (cfg_req) begin
        cfg_pend       <= 1'b1;
        cfg_period_lat <= cfg_period;
        cfg_cont_lat   <= cfg_continuous;
      end
      if (snap_req) begin
        snap_pend <= 1'b1;
      end
    end
  end

endmodule
